alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Synthesisable control-step sequencer for the three-bus datapath. It generates the bus out-select vector, register-enable vector, ALU_Sel, Read and IncPC for a complete fetch-plus-execute of one register-register ALU instruction (T0..T5).
- Generalises the fixed AND sequence in three ways: parametrised step length, full opcode decode, and an extra T6 step for MUL/DIV (writes HI and LO).
- Sits between the instruction-issue logic and the datapath `i` / `reg_enable` / `ALU_Sel` inputs.

Parameters:
- STEP_CYCLES, 4: clocks per control step (≥2).
- SEL_W, 32: width of the out-select and enable vectors.
- ALU_SEL_W, 5: ALU_Sel width.
- ALU_IDLE, 7: ALU_Sel value driven when no ALU operation is active.
- IDX_HI / IDX_LO / IDX_ZHI / IDX_ZLO / IDX_PC / IDX_IR / IDX_MDR / IDX_MAR / IDX_Y: 16 / 17 / 18 / 19 / 20 / 21 / 22 / 23 / 24, bit indices in both vectors. GPRs occupy bits 0-15.

Ports:
- Clock, in, 1: single clock, rising edge.
- clr_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin one instruction; sampled only in IDLE.
- ir_data, in, 32: IR contents. Fields: opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
- i, out, SEL_W: one-hot bus out-select (all zero allowed).
- reg_enable, out, SEL_W: register load enables.
- ALU_Sel, out, ALU_SEL_W: ALU operation.
- Read, out, 1: memory read into MDR.
- IncPC, out, 1: PC increment.
- busy, out, 1: sequence in progress.
- done, out, 1: one-cycle pulse on normal completion.
- illegal, out, 1: one-cycle pulse when the opcode is unsupported.

Behaviour:
- Reset (clr_n=0, async): state=IDLE, step counter=0. Outputs: i=0, reg_enable=0, Read=0, IncPC=0, busy=0, done=0, illegal=0, ALU_Sel=ALU_IDLE. Reset mid-sequence aborts immediately; no pulse is emitted.
- All outputs are registered.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
  - Each T-state lasts exactly STEP_CYCLES clocks, counted by cnt = 0..STEP_CYCLES-1.
  - "Last cycle" means cnt = STEP_CYCLES-1.
- IDLE:
  - start=1 on an edge → T0, busy=1 from that edge.
  - start while busy is ignored; there is no queueing.
- T0: i[IDX_PC]=1 for the whole step. reg_enable[IDX_MAR]=1 and IncPC=1 on the last cycle only.
- T1: Read=1 for the whole step. reg_enable[IDX_MDR]=1 on the last cycle.
- T2: i[IDX_MDR]=1 for the whole step. reg_enable[IDX_IR]=1 on the last cycle.
  - Opcode is decoded from ir_data on the first cycle of T3.
  - Fields are latched on that cycle; later ir_data changes are ignored.
- Decode (opcode → ALU_Sel):
  - 0x03 ADD→0, 0x04 SUB→1, 0x09 AND→3, 0x0A OR→4.
  - 0x0F MUL→8, 0x10 DIV→9, 0x11 NEG→10, 0x12 NOT→11.
  - Any other opcode: illegal pulses for 1 cycle (first cycle of what would be T3), then → IDLE with busy=0 and no done.
- T3: i[rb]=1 for the whole step. reg_enable[IDX_Y]=1 on the last cycle.
- T4: i[rc]=1 for the whole step; NEG/NOT drive i=0 instead. ALU_Sel=decoded value for the whole step.
  - Last cycle: reg_enable[IDX_ZLO]=1. For MUL/DIV, reg_enable[IDX_ZHI]=1 as well.
  - ALU_Sel returns to ALU_IDLE after T4.
- T5:
  - i[IDX_ZLO]=1 for the whole step.
  - Last cycle: reg_enable[ra]=1 for ALU ops, or reg_enable[IDX_LO]=1 for MUL/DIV.
  - Non-MUL/DIV: done=1 on the last cycle, then → IDLE.
- T6 (MUL/DIV only): i[IDX_ZHI]=1 for the whole step. reg_enable[IDX_HI]=1 and done=1 on the last cycle, then → IDLE.
- Latency from the start-sampling edge to the done cycle:
  - 6·STEP_CYCLES clocks (24 at default) for ALU ops.
  - 7·STEP_CYCLES clocks (28 at default) for MUL/DIV.
  - busy falls on the edge after done.
- Invariants:
  - At most one bit of i is set.
  - reg_enable never has a bit set while the same index is set in i.
  - start on the same edge busy falls is ignored; it must be re-asserted in IDLE.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined: adds input step_req (1 bit).
  - On the last cycle of a step, the sequencer holds that cycle, with enables still asserted for only one clock, until step_req=1.
  - It then advances. Held cycles do not re-pulse reg_enable/IncPC/done.
- Undefined: port absent; steps advance unconditionally.

Test Plan:
- Reset: clr_n=0 mid-T3 → within the same cycle all outputs go to reset values, busy=0, ALU_Sel=7; no done.
- AND: ir_data=32'h4A920000, start=1 for one cycle.
  - T3: i[2] set. T4: i[4] set with ALU_Sel=3. T5: i[19] then reg_enable[5].
  - done asserted exactly 24 clocks after the start edge.
- MUL: ir_data=32'h78920000 (opcode 0x0F).
  - T4 last cycle: reg_enable[18] and reg_enable[19] both set.
  - T5 loads LO (bit 17); T6 loads HI (bit 16).
  - done at 28 clocks.
- Illegal: ir_data=32'hF8000000 → illegal pulse on the 13th clock after the start edge (first cycle of T3), busy=0 on the next edge, reg_enable never touches bits 0-15.
- Start while busy: second start pulse during T2 → ignored; exactly one done. IncPC pulses exactly once per instruction (last cycle of T0).
- STEP_CYCLES=2 build, NEG (opcode 0x11, rb=3, ra=7): T4 has i=0 with ALU_Sel=10; reg_enable[7] is set in T5; done at 12 clocks.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for a three-bus datapath: fetch plus execute of one register-register ALU instruction.
// Optional macro SEQ_SINGLE_STEP_EN adds step_req, which holds the last cycle of each step until it is asserted.
module alu_instr_sequencer #(
  parameter int STEP_CYCLES = 4,
  parameter int SEL_W       = 32,
  parameter int ALU_SEL_W   = 5,
  parameter int ALU_IDLE    = 7,
  parameter int IDX_HI      = 16,
  parameter int IDX_LO      = 17,
  parameter int IDX_ZHI     = 18,
  parameter int IDX_ZLO     = 19,
  parameter int IDX_PC      = 20,
  parameter int IDX_IR      = 21,
  parameter int IDX_MDR     = 22,
  parameter int IDX_MAR     = 23,
  parameter int IDX_Y       = 24
) (
  input  logic                 Clock,
  input  logic                 clr_n,
  input  logic                 start,
  input  logic [31:0]          ir_data,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 step_req,
`endif
  output logic [SEL_W-1:0]     i,
  output logic [SEL_W-1:0]     reg_enable,
  output logic [ALU_SEL_W-1:0] ALU_Sel,
  output logic                 Read,
  output logic                 IncPC,
  output logic                 busy,
  output logic                 done,
  output logic                 illegal
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [ALU_SEL_W-1:0] ALU_IDLE_V = ALU_SEL_W'(ALU_IDLE);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_held, w_held_nxt;

  logic [3:0]           r_ra, r_rb, r_rc, w_rb;
  logic [ALU_SEL_W-1:0] r_alu;
  logic                 r_muldiv, r_negnot;

  logic                 w_last, w_first_t3, w_step, w_accept, w_strobe;
  logic                 w_dec_legal, w_dec_muldiv, w_dec_negnot;
  logic [ALU_SEL_W-1:0] w_dec_alu;

  logic [SEL_W-1:0]     w_i, w_en;
  logic [ALU_SEL_W-1:0] w_alu;
  logic                 w_read, w_inc, w_done, w_ill;
  logic                 w_unused;

  function automatic logic [SEL_W-1:0] f_bit(input int idx);
    f_bit = {{(SEL_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign w_unused   = ^ir_data[14:0];
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_first_t3 = (r_state == S_T3) && (r_cnt == '0);
  assign w_accept   = (r_state == S_IDLE) && start && !busy;
  // Strobes fire once per step even if the last cycle is stretched.
  assign w_strobe   = w_last && !r_held;
  assign w_rb       = w_first_t3 ? ir_data[22:19] : r_rb;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_step = step_req;
`else
  assign w_step = 1'b1;
`endif

  always_comb begin
    w_dec_legal  = 1'b1;
    w_dec_muldiv = 1'b0;
    w_dec_negnot = 1'b0;
    w_dec_alu    = ALU_IDLE_V;
    case (ir_data[31:27])
      5'h03: w_dec_alu = ALU_SEL_W'(0);
      5'h04: w_dec_alu = ALU_SEL_W'(1);
      5'h09: w_dec_alu = ALU_SEL_W'(3);
      5'h0A: w_dec_alu = ALU_SEL_W'(4);
      5'h0F: begin w_dec_alu = ALU_SEL_W'(8);  w_dec_muldiv = 1'b1; end
      5'h10: begin w_dec_alu = ALU_SEL_W'(9);  w_dec_muldiv = 1'b1; end
      5'h11: begin w_dec_alu = ALU_SEL_W'(10); w_dec_negnot = 1'b1; end
      5'h12: begin w_dec_alu = ALU_SEL_W'(11); w_dec_negnot = 1'b1; end
      default: w_dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_held_nxt  = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_accept) begin
        w_state_nxt = S_T0;
        w_cnt_nxt   = '0;
      end
    end else if (w_first_t3 && !w_dec_legal) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else if (!w_last) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (!w_step) begin
      w_held_nxt = 1'b1;
    end else begin
      w_cnt_nxt = '0;
      case (r_state)
        S_T0:    w_state_nxt = S_T1;
        S_T1:    w_state_nxt = S_T2;
        S_T2:    w_state_nxt = S_T3;
        S_T3:    w_state_nxt = S_T4;
        S_T4:    w_state_nxt = S_T5;
        S_T5:    w_state_nxt = r_muldiv ? S_T6 : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_i    = '0;
    w_en   = '0;
    w_alu  = ALU_IDLE_V;
    w_read = 1'b0;
    w_inc  = 1'b0;
    w_done = 1'b0;
    w_ill  = 1'b0;
    case (r_state)
      S_T0: begin
        w_i = f_bit(IDX_PC);
        if (w_strobe) begin
          w_en  = f_bit(IDX_MAR);
          w_inc = 1'b1;
        end
      end
      S_T1: begin
        w_read = 1'b1;
        if (w_strobe) w_en = f_bit(IDX_MDR);
      end
      S_T2: begin
        w_i = f_bit(IDX_MDR);
        if (w_strobe) w_en = f_bit(IDX_IR);
      end
      S_T3: begin
        if (w_first_t3 && !w_dec_legal) begin
          w_ill = 1'b1;
        end else begin
          w_i = f_bit(int'(w_rb));
          if (w_strobe) w_en = f_bit(IDX_Y);
        end
      end
      S_T4: begin
        if (!r_negnot) w_i = f_bit(int'(r_rc));
        w_alu = r_alu;
        if (w_strobe) w_en = f_bit(IDX_ZLO) | (r_muldiv ? f_bit(IDX_ZHI) : '0);
      end
      S_T5: begin
        w_i = f_bit(IDX_ZLO);
        if (w_strobe) begin
          w_en   = r_muldiv ? f_bit(IDX_LO) : f_bit(int'(r_ra));
          w_done = !r_muldiv;
        end
      end
      S_T6: begin
        w_i = f_bit(IDX_ZHI);
        if (w_strobe) begin
          w_en   = f_bit(IDX_HI);
          w_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge Clock or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_held     <= 1'b0;
      i          <= '0;
      reg_enable <= '0;
      ALU_Sel    <= ALU_IDLE_V;
      Read       <= 1'b0;
      IncPC      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_held     <= w_held_nxt;
      i          <= w_i;
      reg_enable <= w_en;
      ALU_Sel    <= w_alu;
      Read       <= w_read;
      IncPC      <= w_inc;
      busy       <= (r_state != S_IDLE) || w_accept;
      done       <= w_done;
      illegal    <= w_ill;
    end
  end

  // Instruction fields captured once, on the first cycle of T3
  always_ff @(posedge Clock) begin
    if (w_first_t3) begin
      r_ra     <= ir_data[26:23];
      r_rb     <= ir_data[22:19];
      r_rc     <= ir_data[18:15];
      r_alu    <= w_dec_alu;
      r_muldiv <= w_dec_muldiv;
      r_negnot <= w_dec_negnot;
    end
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomised bench for alu_instr_sequencer at STEP_CYCLES=4 and STEP_CYCLES=2, checked cycle by cycle against a timeline model.
module tb_alu_instr_sequencer;

  logic        Clock = 1'b0;
  logic        clr_n;
  logic [1:0]  start_v;
  logic [31:0] ir_data;

  logic [31:0] i_a, en_a, i_b, en_b;
  logic [4:0]  alu_a, alu_b;
  logic        rd_a, inc_a, bsy_a, dn_a, ill_a;
  logic        rd_b, inc_b, bsy_b, dn_b, ill_b;
  logic [73:0] obs [2];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [73:0] RST_V = {32'h0, 32'h0, 5'd7, 5'b0};

  always #5 Clock = ~Clock;

  alu_instr_sequencer #(.STEP_CYCLES(4)) u_dut4 (
    .Clock(Clock), .clr_n(clr_n), .start(start_v[0]), .ir_data(ir_data),
`ifdef SEQ_SINGLE_STEP_EN
    .step_req(1'b1),
`endif
    .i(i_a), .reg_enable(en_a), .ALU_Sel(alu_a), .Read(rd_a), .IncPC(inc_a),
    .busy(bsy_a), .done(dn_a), .illegal(ill_a)
  );

  alu_instr_sequencer #(.STEP_CYCLES(2)) u_dut2 (
    .Clock(Clock), .clr_n(clr_n), .start(start_v[1]), .ir_data(ir_data),
`ifdef SEQ_SINGLE_STEP_EN
    .step_req(1'b1),
`endif
    .i(i_b), .reg_enable(en_b), .ALU_Sel(alu_b), .Read(rd_b), .IncPC(inc_b),
    .busy(bsy_b), .done(dn_b), .illegal(ill_b)
  );

  assign obs[0] = {i_a, en_a, alu_a, rd_a, inc_a, bsy_a, dn_a, ill_a};
  assign obs[1] = {i_b, en_b, alu_b, rd_b, inc_b, bsy_b, dn_b, ill_b};

  task automatic chk(input string tag, input logic [73:0] got, input logic [73:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void decode(input logic [4:0] op, output logic legal,
                                 output logic [4:0] alu, output logic md, output logic nn);
    legal = 1'b1; md = 1'b0; nn = 1'b0; alu = 5'd7;
    case (op)
      5'h03: alu = 5'd0;
      5'h04: alu = 5'd1;
      5'h09: alu = 5'd3;
      5'h0A: alu = 5'd4;
      5'h0F: begin alu = 5'd8;  md = 1'b1; end
      5'h10: begin alu = 5'd9;  md = 1'b1; end
      5'h11: begin alu = 5'd10; nn = 1'b1; end
      5'h12: begin alu = 5'd11; nn = 1'b1; end
      default: legal = 1'b0;
    endcase
  endfunction

  // Expected outputs in the cycle following the k-th edge after the start-sampling edge (k=0).
  function automatic logic [73:0] exp_out(input int sc, input logic [31:0] ir, input int k);
    logic [31:0] iv, en;
    logic [4:0]  alu, code;
    logic        rd, inc, bsy, dn, ill, legal, md, nn, last;
    int          total, s;
    iv = '0; en = '0; alu = 5'd7; rd = 0; inc = 0; bsy = 0; dn = 0; ill = 0;
    decode(ir[31:27], legal, code, md, nn);
    total = (md ? 7 : 6) * sc;
    if (k == 0) begin
      bsy = 1'b1;
    end else if (!legal && k > 3 * sc) begin
      if (k == 3 * sc + 1) begin ill = 1'b1; bsy = 1'b1; end
    end else if (k <= total) begin
      bsy  = 1'b1;
      s    = (k - 1) / sc;
      last = ((k - 1) % sc) == sc - 1;
      case (s)
        0: begin iv[20] = 1'b1; if (last) begin en[23] = 1'b1; inc = 1'b1; end end
        1: begin rd = 1'b1; if (last) en[22] = 1'b1; end
        2: begin iv[21 + 1] = 1'b1; if (last) en[21] = 1'b1; end
        3: begin iv = 32'd1 << ir[22:19]; if (last) en[24] = 1'b1; end
        4: begin
          if (!nn) iv = 32'd1 << ir[18:15];
          alu = code;
          if (last) begin en[19] = 1'b1; en[18] = md; end
        end
        5: begin
          iv[19] = 1'b1;
          if (last) begin
            if (md) en[17] = 1'b1; else en = 32'd1 << ir[26:23];
            dn = !md;
          end
        end
        default: begin iv[18] = 1'b1; if (last) begin en[16] = 1'b1; dn = 1'b1; end end
      endcase
    end
    return {iv, en, alu, rd, inc, bsy, dn, ill};
  endfunction

  // extra: 0 none, 1 second start during T2, 2 start held on the edge where busy falls
  task automatic run_instr(input int d, input logic [31:0] ir, input int extra);
    int sc, total, e, dn_cnt, inc_cnt, ill_cnt;
    logic legal, md, nn;
    logic [4:0] code;
    sc = (d == 0) ? 4 : 2;
    decode(ir[31:27], legal, code, md, nn);
    total = (md ? 7 : 6) * sc;
    dn_cnt = 0; inc_cnt = 0; ill_cnt = 0; e = -1;
    if (extra == 1) e = 2 * sc + $urandom_range(sc - 1, 0);
    if (extra == 2) e = legal ? total + 1 : 3 * sc + 2;
    @(negedge Clock);
    ir_data = ir;
    start_v[d] = 1'b1;
    for (int k = 0; k <= 7 * sc + 4; k++) begin
      @(negedge Clock);
      chk($sformatf("trace dut%0d ir=%h k=%0d", d, ir, k), obs[d], exp_out(sc, ir, k));
      chk($sformatf("onehot_i dut%0d k=%0d", d, k), 74'($countones(obs[d][73:42]) <= 1), 74'(1));
      chk($sformatf("i_en_overlap dut%0d k=%0d", d, k), 74'(|(obs[d][73:42] & obs[d][41:10])), 74'(0));
      if (obs[d][1]) dn_cnt++;
      if (obs[d][3]) inc_cnt++;
      if (obs[d][0]) ill_cnt++;
      start_v[d] = (k + 1 == e);
      if (k >= 3 * sc + 1) ir_data = $urandom;
    end
    chk($sformatf("done_count dut%0d ir=%h", d, ir), 74'(dn_cnt), legal ? 74'(1) : 74'(0));
    chk($sformatf("incpc_count dut%0d ir=%h", d, ir), 74'(inc_cnt), 74'(1));
    chk($sformatf("illegal_count dut%0d ir=%h", d, ir), 74'(ill_cnt), legal ? 74'(0) : 74'(1));
  endtask

  task automatic reset_mid_t3(input int d, input logic [31:0] ir);
    int sc;
    sc = (d == 0) ? 4 : 2;
    @(negedge Clock);
    ir_data = ir;
    start_v[d] = 1'b1;
    for (int k = 0; k <= 3 * sc + 2; k++) begin
      @(negedge Clock);
      chk($sformatf("pre_rst dut%0d k=%0d", d, k), obs[d], exp_out(sc, ir, k));
      start_v[d] = 1'b0;
    end
    #2 clr_n = 1'b0;
    #1 chk($sformatf("rst_async dut%0d", d), obs[d], RST_V);
    @(posedge Clock);
    #1 chk($sformatf("rst_hold dut%0d", d), obs[d], RST_V);
    @(negedge Clock);
    clr_n = 1'b1;
    for (int k = 0; k < 8 * sc; k++) begin
      @(negedge Clock);
      chk($sformatf("post_rst_idle dut%0d k=%0d", d, k), obs[d], RST_V);
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] ops [8];
    logic [4:0] op;
    logic leg, md, nn;
    logic [4:0] code;
    ops = '{5'h03, 5'h04, 5'h09, 5'h0A, 5'h0F, 5'h10, 5'h11, 5'h12};
    if ($urandom_range(3, 0) != 0) begin
      op = ops[$urandom_range(7, 0)];
    end else begin
      op = 5'($urandom);
      decode(op, leg, code, md, nn);
      if (leg) op = 5'h1F;
    end
    return {op, 27'($urandom)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    start_v = 2'b00;
    ir_data = '0;
    repeat (2) @(negedge Clock);
    chk("reset_dut4", obs[0], RST_V);
    chk("reset_dut2", obs[1], RST_V);
    clr_n = 1'b1;

    run_instr(0, 32'h4A920000, 0);
    run_instr(0, 32'h78920000, 0);
    run_instr(0, 32'hF8000000, 0);
    run_instr(0, 32'h4A920000, 1);
    run_instr(0, 32'h78920000, 2);
    run_instr(0, 32'hF8000000, 2);
    run_instr(1, 32'h8B980000, 0);
    run_instr(1, 32'h80000000, 2);
    reset_mid_t3(0, 32'h4A920000);
    reset_mid_t3(1, 32'h78920000);

    for (int n = 0; n < 40; n++) begin
      run_instr(int'($urandom_range(1, 0)), rand_ir(), int'($urandom_range(2, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
